// File: rtl/race_distance_tracker.sv
// ---------------------------------------------------------------------------
// race_distance_tracker
//
// Per-frame player speed integrator and race-progress FSM. Accelerate, brake
// and crash events become a saturating speed. Once per video frame that speed
// is added into a 32-bit distance that never wraps. When the finish distance
// is crossed, a one-clk finish_reached pulse is raised. After the finish the
// car coasts to a stop while the distance keeps growing, so the finish line
// keeps scrolling.
//
// Optional feature (macro RACE_BOOST_EN):
//   Adds a boost input. In RACING, boost with accel raises the speed ceiling
//   to MAX_SPEED + MAX_SPEED/2 and doubles the gain. Once boost is released,
//   a speed above MAX_SPEED decays by BRAKE_STEP per frame until it is back
//   at or under MAX_SPEED.
//
// Ports:
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   frame_start    in   one-clk pulse per frame; all updates happen then
//   race_enable    in   1 = race running, 0 = return to IDLE
//   accel          in   accelerate key (level)
//   brake          in   brake key (level), wins over accel
//   crash          in   collision pulse, any length, any cycle
//   boost          in   boost key (only with RACE_BOOST_EN)
//   distance_drove out  accumulated distance (signed 32, never negative)
//   speed          out  current speed, 0..ceiling
//   race_state     out  0 IDLE, 1 RACING, 2 CRASHED, 3 FINISHED
//   finish_reached out  one-clk pulse on entry to FINISHED
// ---------------------------------------------------------------------------
module race_distance_tracker #(
    parameter logic [10:0] MAX_SPEED       = 11'd400,
    parameter logic [10:0] ACCEL_STEP      = 11'd4,
    parameter logic [10:0] BRAKE_STEP      = 11'd8,
    parameter logic [10:0] DRAG_STEP       = 11'd1,
    parameter logic [7:0]  CRASH_FRAMES    = 8'd60,
    parameter logic [31:0] FINISH_DISTANCE = 32'd100000
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frame_start,
    input  logic               race_enable,
    input  logic               accel,
    input  logic               brake,
    input  logic               crash,
`ifdef RACE_BOOST_EN
    input  logic               boost,
`endif
    output logic signed [31:0] distance_drove,
    output logic [10:0]        speed,
    output logic [1:0]         race_state,
    output logic               finish_reached
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RACING   = 2'd1,
        ST_CRASHED  = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    localparam logic [31:0] DIST_MAX = 32'h7FFF_FFFF;
`ifdef RACE_BOOST_EN
    localparam logic [10:0] BOOST_MAX = MAX_SPEED + (MAX_SPEED >> 1);
`endif

    state_t      state_r, state_s;
    logic [10:0] speed_r, speed_s;
    logic [31:0] distance_r, distance_s;
    logic [7:0]  count_r, count_s;
    logic        finish_r, finish_s;
    logic        crash_pending_r, crash_pending_s;
    logic        crash_eff_s;
    logic [10:0] ceil_s;
    logic [10:0] gain_s;
    logic [10:0] racing_speed_s;

    // Speed add clamped to the active ceiling.
    function automatic logic [10:0] speed_add(input logic [10:0] cur,
                                              input logic [10:0] step,
                                              input logic [10:0] ceil_v);
        logic [11:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, ceil_v}) begin
            speed_add = ceil_v;
        end else begin
            speed_add = sum[10:0];
        end
    endfunction

    // Speed subtract clamped at zero.
    function automatic logic [10:0] speed_sub(input logic [10:0] cur,
                                              input logic [10:0] step);
        if (cur < step) begin
            speed_sub = 11'd0;
        end else begin
            speed_sub = cur - step;
        end
    endfunction

    // Distance add done in 33 bits so the carry is visible, then clamped to
    // the largest positive int so downstream signed consumers never see a
    // sign flip.
    function automatic logic [31:0] dist_add(input logic [31:0] cur,
                                             input logic [10:0] spd);
        logic [32:0] sum;
        sum = {1'b0, cur} + {22'd0, spd};
        if (sum > {1'b0, DIST_MAX}) begin
            dist_add = DIST_MAX;
        end else begin
            dist_add = sum[31:0];
        end
    endfunction

    // Pedal-driven speed candidate used while RACING.
    always_comb begin
        ceil_s = MAX_SPEED;
        gain_s = ACCEL_STEP;
`ifdef RACE_BOOST_EN
        if (boost && accel) begin
            ceil_s = BOOST_MAX;
            gain_s = ACCEL_STEP << 1;
        end else begin
            ceil_s = MAX_SPEED;
            gain_s = ACCEL_STEP;
        end
`endif
        if (brake) begin
            racing_speed_s = speed_sub(speed_r, BRAKE_STEP);
        end else if (speed_r > ceil_s) begin
            // Left over from a released boost: bleed back under the ceiling.
            racing_speed_s = speed_sub(speed_r, BRAKE_STEP);
        end else if (accel) begin
            racing_speed_s = speed_add(speed_r, gain_s, ceil_s);
        end else begin
            racing_speed_s = speed_sub(speed_r, DRAG_STEP);
        end
    end

    // Next-state logic: FSM, speed, distance, crash counter and crash latch.
    always_comb begin
        state_s         = state_r;
        speed_s         = speed_r;
        distance_s      = distance_r;
        count_s         = count_r;
        finish_s        = 1'b0;
        // A crash on the frame_start cycle itself still counts for this frame.
        crash_eff_s     = crash_pending_r | crash;
        crash_pending_s = crash_pending_r | crash;

        if (frame_start) begin
            crash_pending_s = 1'b0;
            if (!race_enable) begin
                state_s    = ST_IDLE;
                speed_s    = 11'd0;
                distance_s = 32'd0;
                count_s    = 8'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_s    = ST_RACING;
                        speed_s    = 11'd0;
                        distance_s = 32'd0;
                    end
                    ST_RACING: begin
                        distance_s = dist_add(distance_r, speed_r);
                        if (distance_s >= FINISH_DISTANCE) begin
                            state_s  = ST_FINISHED;
                            speed_s  = racing_speed_s;
                            finish_s = 1'b1;
                        end else if (crash_eff_s) begin
                            state_s = ST_CRASHED;
                            speed_s = 11'd0;
                            count_s = CRASH_FRAMES - 8'd1;
                        end else begin
                            speed_s = racing_speed_s;
                        end
                    end
                    ST_CRASHED: begin
                        speed_s = 11'd0;
                        if (count_r == 8'd0) begin
                            state_s = ST_RACING;
                        end else begin
                            count_s = count_r - 8'd1;
                        end
                    end
                    ST_FINISHED: begin
                        distance_s = dist_add(distance_r, speed_r);
                        speed_s    = speed_sub(speed_r, BRAKE_STEP);
                    end
                    default: begin
                        state_s    = ST_IDLE;
                        speed_s    = 11'd0;
                        distance_s = 32'd0;
                        count_s    = 8'd0;
                    end
                endcase
            end
        end else begin
            finish_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r         <= ST_IDLE;
            speed_r         <= 11'd0;
            distance_r      <= 32'd0;
            count_r         <= 8'd0;
            finish_r        <= 1'b0;
            crash_pending_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            speed_r         <= speed_s;
            distance_r      <= distance_s;
            count_r         <= count_s;
            finish_r        <= finish_s;
            crash_pending_r <= crash_pending_s;
        end
    end

    assign distance_drove = distance_r;
    assign speed          = speed_r;
    assign race_state     = state_r;
    assign finish_reached = finish_r;

endmodule

// File: tb/tb_race_distance_tracker.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for race_distance_tracker (default build).
// ---------------------------------------------------------------------------
module tb_race_distance_tracker;

    logic               clk = 1'b0;
    logic               resetN;
    logic               frame_start;
    logic               race_enable;
    logic               accel;
    logic               brake;
    logic               crash;
    logic signed [31:0] distance_drove;
    logic [10:0]        speed;
    logic [1:0]         race_state;
    logic               finish_reached;

    int errors = 0;
    int checks = 0;
    int finish_pulses = 0;

    race_distance_tracker dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .race_enable    (race_enable),
        .accel          (accel),
        .brake          (brake),
        .crash          (crash),
        .distance_drove (distance_drove),
        .speed          (speed),
        .race_state     (race_state),
        .finish_reached (finish_reached)
    );

    always #5 clk = ~clk;

    // Counts finish pulses; a pulse lasts one full clk so one negedge sees it.
    always @(negedge clk) begin
        if (finish_reached) finish_pulses <= finish_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Two idle cycles, then one frame_start cycle; returns on the negedge
    // right after the updating edge.
    task automatic frame();
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic crash_pulse();
        @(negedge clk);
        crash = 1'b1;
        @(negedge clk);
        crash = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; frame_start = 1'b0; race_enable = 1'b0;
        accel = 1'b0; brake = 1'b0; crash = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dist", distance_drove, 32'd0);
        check("rst_speed", {21'd0, speed}, 32'd0);
        check("rst_state", {30'd0, race_state}, 32'd0);
        check("rst_finish", {31'd0, finish_reached}, 32'd0);
        resetN = 1'b1;

        // Start and accelerate to saturation.
        race_enable = 1'b1; accel = 1'b1;
        frame();
        check("start_state", {30'd0, race_state}, 32'd1);
        check("start_speed", {21'd0, speed}, 32'd0);
        repeat (100) frame();
        check("sat_speed", {21'd0, speed}, 32'd400);
        check("sat_dist101", distance_drove, 32'd19800);
        frame();
        check("sat_hold", {21'd0, speed}, 32'd400);
        check("sat_dist102", distance_drove, 32'd20200);
        repeat (3) @(negedge clk);
        check("hold_between", distance_drove, 32'd20200);

        // Brake down to 200, then brake and accel together.
        accel = 1'b0; brake = 1'b1;
        repeat (25) frame();
        check("brake_speed", {21'd0, speed}, 32'd200);
        check("brake_dist", distance_drove, 32'd27800);
        accel = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            frame();
            check("both_speed", {21'd0, speed}, 32'(200 - 8 * i));
        end
        check("both_dist", distance_drove, 32'd28376);

        // Up to 300, then crash mid-frame.
        brake = 1'b0;
        repeat (31) frame();
        check("pre_crash_speed", {21'd0, speed}, 32'd300);
        check("pre_crash_dist", distance_drove, 32'd35692);
        crash_pulse();
        frame();
        check("crash_state", {30'd0, race_state}, 32'd2);
        check("crash_speed", {21'd0, speed}, 32'd0);
        check("crash_dist", distance_drove, 32'd35992);
        for (int i = 0; i < 59; i++) begin
            if (i == 10) crash_pulse();
            frame();
        end
        check("crashed_state", {30'd0, race_state}, 32'd2);
        check("crashed_dist", distance_drove, 32'd35992);
        frame();
        check("recover_state", {30'd0, race_state}, 32'd1);
        check("recover_speed", {21'd0, speed}, 32'd0);
        frame();
        check("second_crash_ignored", {30'd0, race_state}, 32'd1);
        check("recover_accel", {21'd0, speed}, 32'd4);
        check("recover_dist", distance_drove, 32'd35992);

        // Run toward the finish.
        repeat (99) frame();
        check("ramp_dist", distance_drove, 32'd55792);
        repeat (110) frame();
        check("near_state", {30'd0, race_state}, 32'd1);
        check("near_dist", distance_drove, 32'd99792);
        // Preload so the next add lands exactly on the finish distance.
        @(negedge clk);
        force dut.distance_r = 32'd99600;
        @(negedge clk);
        release dut.distance_r;
        crash = 1'b1;
        frame();
        crash = 1'b0;
        check("fin_state", {30'd0, race_state}, 32'd3);
        check("fin_dist", distance_drove, 32'd100000);
        check("fin_pulse", {31'd0, finish_reached}, 32'd1);
        @(negedge clk);
        check("fin_pulse_end", {31'd0, finish_reached}, 32'd0);
        frame();
        check("coast_speed1", {21'd0, speed}, 32'd392);
        check("coast_dist1", distance_drove, 32'd100400);
        frame();
        check("coast_speed2", {21'd0, speed}, 32'd384);
        check("coast_dist2", distance_drove, 32'd100792);

        // Saturation of distance near the int limit.
        @(negedge clk);
        force dut.distance_r = 32'd2147483600;
        @(negedge clk);
        release dut.distance_r;
        frame();
        check("dist_sat", distance_drove, 32'd2147483647);
        check("dist_sat_speed", {21'd0, speed}, 32'd376);
        frame();
        check("dist_sat_hold", distance_drove, 32'd2147483647);
        repeat (46) frame();
        check("coast_zero", {21'd0, speed}, 32'd0);
        frame();
        check("coast_zero_hold", {21'd0, speed}, 32'd0);
        check("fin_state_hold", {30'd0, race_state}, 32'd3);
        check("finish_once", 32'(finish_pulses), 32'd1);

        // Return to IDLE from FINISHED.
        race_enable = 1'b0;
        frame();
        check("idle_state", {30'd0, race_state}, 32'd0);
        check("idle_dist", distance_drove, 32'd0);
        check("idle_speed", {21'd0, speed}, 32'd0);

        // New race, drag, then disable mid-race.
        race_enable = 1'b1;
        frame();
        repeat (3) frame();
        check("r2_speed", {21'd0, speed}, 32'd12);
        check("r2_dist", distance_drove, 32'd12);
        accel = 1'b0;
        frame();
        check("drag_speed", {21'd0, speed}, 32'd11);
        check("drag_dist", distance_drove, 32'd24);
        race_enable = 1'b0;
        frame();
        check("mid_idle_state", {30'd0, race_state}, 32'd0);
        check("mid_idle_dist", distance_drove, 32'd0);
        check("mid_idle_speed", {21'd0, speed}, 32'd0);

        // Async reset mid-race, checked before any clock edge.
        race_enable = 1'b1; accel = 1'b1;
        frame();
        repeat (3) frame();
        check("r3_speed", {21'd0, speed}, 32'd12);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("async_dist", distance_drove, 32'd0);
        check("async_speed", {21'd0, speed}, 32'd0);
        check("async_state", {30'd0, race_state}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
